mac_operand_sequencer: RTL
==========================

Name: mac_operand_sequencer

Overview:
- Drives the operand side of a GenericMacUnit: it fetches paired operands from two synchronous-read buffers and streams them with `enable` for exactly AccCycles products.
- It then waits for the accumulator to settle, captures AccResult, and presents it with a valid/ack handshake.
- It sits between the kernel/window buffers and the MAC, and is the control owner of each dot-product job.

Parameters:
- bitwidthA, 8, operand A width; matches the MAC.
- bitwidthB, 8, operand B width; matches the MAC.
- AccCycles, 400, products per job; must be ≥1.
- bitwidthAccRes, 25, accumulated result width.
- AddrWidth, 9, buffer address width; requires 2^AddrWidth ≥ AccCycles.
- ResLatency, 1, cycles from the last `enable` cycle until AccResult is stable; must be ≥0.

Ports:
- clock, input, 1, single system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, job request; sampled only in IDLE.
- busy, output, 1, high in every state except IDLE.
- memRdEn, output, 1, buffer read strobe.
- addrA, output, AddrWidth, operand A buffer address.
- addrB, output, AddrWidth, operand B buffer address.
- memDataA, input, bitwidthA, A buffer read data, valid 1 cycle after memRdEn.
- memDataB, input, bitwidthB, B buffer read data, valid 1 cycle after memRdEn.
- accClear, output, 1, one-cycle clear pulse to the accumulator.
- enable, output, 1, MAC enable.
- operandA, output, bitwidthA, MAC operand A.
- operandB, output, bitwidthB, MAC operand B.
- AccResult, input, bitwidthAccRes, MAC accumulated result.
- result, output, bitwidthAccRes, captured job result.
- resultValid, output, 1, result available.
- resultAck, input, 1, consumer accepts result.

Behaviour:
- **Reset (async, reset=0).** State goes to IDLE. busy, memRdEn, accClear, enable and resultValid go to 0 immediately. addrA, addrB, result and the internal counters go to 0. Reset mid-job abandons the job with no partial result.
- **States.** IDLE, CLEAR, FETCH, DRAIN, SETTLE, HOLD.
- **IDLE.** If start=1 at the edge, go to CLEAR; otherwise stay.
- **CLEAR.** accClear=1 for exactly one cycle; the address counter is 0. Go to FETCH.
- **FETCH.**
  - memRdEn=1; addrA=addrB=count.
  - count runs 0..AccCycles-1, incrementing each cycle, so it is high for exactly AccCycles cycles.
  - When count=AccCycles-1, go to DRAIN. The counter does not wrap inside a job.
- **Enable pipeline.** enable is memRdEn registered by one cycle. operandA=memDataA and operandB=memDataB (pass-through), so operands align with enable by construction. Consequently enable is high for exactly AccCycles consecutive cycles, starting one cycle after FETCH begins.
- **DRAIN.** One cycle; carries the final enable. memRdEn=0.
- **SETTLE.**
  - Counts ResLatency cycles, then captures AccResult into result and sets resultValid=1, entering HOLD.
  - With ResLatency=0, capture happens at the DRAIN exit edge and SETTLE is skipped.
- **HOLD.**
  - result is held stable and resultValid=1 until resultAck=1 is seen at an edge. Then go to IDLE and resultValid goes to 0 on that same edge.
  - resultAck outside HOLD is ignored.
- **Timing from the start edge (cycle 0, the edge sampling start).**
  - accClear is high in cycle 1.
  - memRdEn is high in cycles 2..AccCycles+1.
  - enable is high in cycles 3..AccCycles+2.
  - resultValid rises at the edge ending cycle AccCycles+2+ResLatency.
- **start handling.** start while busy is ignored; it is not queued. A start coincident with resultAck in HOLD is also ignored: start must be high in IDLE. The earliest back-to-back restart is one cycle after the ack edge.
- **Arithmetic.** This block performs none. Width checks are the integrator's responsibility: bitwidthAccRes ≥ bitwidthA+bitwidthB+ceil(log2(AccCycles)).
- **Address outputs.** Addresses hold their last value outside FETCH. memRdEn is the only qualifier.

Test Plan:
- AccCycles=4, A buffer={1,2,3,4}, B buffer={5,6,7,8}, ResLatency=1, start pulse → result=70 with resultValid exactly at cycle 7 after start. enable is high in cycles 3–6, accClear only in cycle 1, addrA sequence 0,1,2,3.
- AccCycles=4, all operands 255 → result=260100. enable count is exactly 4 (checked with a counter monitor).
- Hold resultAck low for 10 cycles in HOLD → result and resultValid stable, busy=1. Pulse ack → resultValid=0 and busy=0 on that edge.
- Assert start continuously from cycle 2 through the end of the job, with ack and start together in HOLD → no restart until start is sampled in IDLE. Second job result is again 70, and accClear pulses once per job.
- Drive reset low mid-FETCH at count=2 → busy, enable, memRdEn and resultValid drop asynchronously with no clock edge. After release, a new start yields a correct result of 70.
- ResLatency=0 and AccCycles=1, A={9}, B={7} → result=63 with resultValid at cycle 3 after start.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mac_operand_sequencer
//
// Operand-side controller for a generic multiply-accumulate unit. One job:
// pulse accClear, read AccCycles operand pairs from two synchronous-read
// buffers, stream them to the MAC under 'enable', wait ResLatency cycles for
// the accumulator to settle, then hold the captured sum under a valid/ack
// handshake.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low
//   start        job request, only sampled while idle
//   busy         high in every state except idle
//   memRdEn      buffer read strobe (high for exactly AccCycles cycles)
//   addrA/addrB  buffer addresses, hold last value outside the fetch phase
//   memDataA/B   buffer read data, valid one cycle after memRdEn
//   accClear     one-cycle accumulator clear pulse
//   enable       MAC enable, memRdEn delayed by one cycle
//   operandA/B   MAC operands, pass-through of buffer read data
//   AccResult    accumulated result from the MAC
//   result       captured job result
//   resultValid  result available, held until resultAck
//   resultAck    consumer accepts result (ignored outside the hold phase)
// -----------------------------------------------------------------------------
module mac_operand_sequencer #(
  parameter int bitwidthA      = 8,
  parameter int bitwidthB      = 8,
  parameter int AccCycles      = 400,
  parameter int bitwidthAccRes = 25,
  parameter int AddrWidth      = 9,
  parameter int ResLatency     = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      memRdEn,
  output logic [AddrWidth-1:0]      addrA,
  output logic [AddrWidth-1:0]      addrB,
  input  logic [bitwidthA-1:0]      memDataA,
  input  logic [bitwidthB-1:0]      memDataB,
  output logic                      accClear,
  output logic                      enable,
  output logic [bitwidthA-1:0]      operandA,
  output logic [bitwidthB-1:0]      operandB,
  input  logic [bitwidthAccRes-1:0] AccResult,
  output logic [bitwidthAccRes-1:0] result,
  output logic                      resultValid,
  input  logic                      resultAck
);

  // Settle counter only needs to reach ResLatency-1; keep at least one bit so
  // the ResLatency=0 build still elaborates.
  localparam int SettleW = (ResLatency > 1) ? $clog2(ResLatency) : 1;
  localparam logic [AddrWidth-1:0] LastCount  = AddrWidth'(AccCycles - 1);
  localparam logic [SettleW-1:0]   LastSettle = SettleW'((ResLatency > 0) ? ResLatency - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_SETTLE,
    S_HOLD
  } state_e;

  state_e                    state_q, state_d;
  logic [AddrWidth-1:0]      count_q, count_d;
  logic [SettleW-1:0]        settle_q, settle_d;
  logic [bitwidthAccRes-1:0] result_q, result_d;
  logic                      enable_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      settle_q <= '0;
      result_q <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      settle_q <= settle_d;
      result_q <= result_d;
      // Read data arrives one cycle after the strobe, so delaying the strobe
      // by one cycle lines enable up with the pass-through operands.
      enable_q <= (state_q == S_FETCH);
    end
  end

  // NOTE: every variable gets a hold-value default before the case statement,
  // so no path through the block leaves one unassigned and no latch appears.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    settle_d = settle_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          count_d = '0;
        end
      end

      S_CLEAR: state_d = S_FETCH;

      S_FETCH: begin
        // Stop at the last address; the counter never wraps within a job.
        if (count_q == LastCount) begin
          state_d = S_DRAIN;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      S_DRAIN: begin
        // The final enable is in this cycle. With no result latency the MAC
        // output already includes it, so capture on this exit edge.
        if (ResLatency == 0) begin
          result_d = AccResult;
          state_d  = S_HOLD;
        end else begin
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (settle_q == LastSettle) begin
          result_d = AccResult;
          state_d  = S_HOLD;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (resultAck) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decode the state register directly so an asynchronous
  // reset drops them without waiting for a clock edge.
  assign busy        = (state_q != S_IDLE);
  assign accClear    = (state_q == S_CLEAR);
  assign memRdEn     = (state_q == S_FETCH);
  assign resultValid = (state_q == S_HOLD);
  assign enable      = enable_q;
  assign addrA       = count_q;
  assign addrB       = count_q;
  assign operandA    = memDataA;
  assign operandB    = memDataB;
  assign result      = result_q;

endmodule
